shift_sub_divider: RTL and testbench

SHIFT_SUB_DIVIDER -- requirements
Module: shift_sub_divider

---
 rtl/shift_sub_divider_pkg.sv | 15 +
 rtl/div_trial_sub.sv | 28 ++
 rtl/shift_sub_divider.sv | 159 +++++++++++++++
 tb/tb_shift_sub_divider.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_sub_divider_pkg.sv
// Shared definitions for the shift/subtract divider.
//   DEFAULT_WIDTH : default operand/result width
//   state_t       : divider FSM state encoding (IDLE, CALC, SIGN, DONE)
package shift_sub_divider_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_trial_sub.sv
// Ripple-carry subtractor used for the restoring-division trial step.
// Ports:
//   i_a      : minuend
//   i_b      : subtrahend
//   o_diff   : i_a - i_b (modulo 2^W)
//   o_borrow : 1 when i_b > i_a (unsigned), i.e. the trial result is negative
module div_trial_sub #(
  parameter int W = 33
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_diff,
  output logic         o_borrow
);

  logic [W:0] w_borrow;

  assign w_borrow[0] = 1'b0;

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign o_diff[gi]       = i_a[gi] ^ i_b[gi] ^ w_borrow[gi];
    assign w_borrow[gi + 1] = (~i_a[gi] & i_b[gi]) |
                              (~(i_a[gi] ^ i_b[gi]) & w_borrow[gi]);
  end

  assign o_borrow = w_borrow[W];

endmodule

// File: rtl/shift_sub_divider.sv
// Signed restoring divider, one quotient bit per clock.
// Build option: define SHIFT_SUB_DIVIDER_DIV0_DETECT_EN to short-circuit a
// zero divisor (result after two edges, div_by_zero flagged). Without it a
// zero divisor runs the full algorithm and div_by_zero stays 0.
// Handshake: an operation is accepted on a rising edge where
// in_valid && in_ready; a result is consumed on a rising edge where
// out_valid && out_ready. in_ready is high only in IDLE, out_valid only in DONE.
// Ports:
//   clk, rst_n            : clock (rising edge), async active-low reset
//   in_valid, in_ready    : operand handshake
//   dividend, divisor     : signed operands, sampled on the accept edge
//   out_valid, out_ready  : result handshake
//   quotient, remainder   : signed results, truncation toward zero
//   div_by_zero           : result came from a zero divisor
//   o_dbg_state           : current FSM state
module shift_sub_divider
  import shift_sub_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       o_dbg_state
);

  localparam int                CW        = $clog2(WIDTH);
  localparam logic [CW-1:0]     LAST_STEP = CW'(WIDTH - 1);
  localparam logic [CW-1:0]     CNT_ONE   = CW'(1);
  localparam logic [WIDTH-1:0]  ONE       = WIDTH'(1);

  state_t           r_state, w_next_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dvd;      // dividend magnitude, shifted out MSB first
  logic [WIDTH-1:0] r_dvs;      // divisor magnitude
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;      // partial remainder, final remainder after SIGN
  logic             r_qsign;
  logic             r_rsign;
  logic             r_out_valid;
  logic             w_skip;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_borrow;
  logic             w_unused_diff_msb;

  // Shift the next dividend bit into the partial remainder and try the subtract.
  assign w_shift = {r_rem, r_dvd[WIDTH-1]};

  div_trial_sub #(.W(WIDTH + 1)) u_trial_sub (
    .i_a      (w_shift),
    .i_b      ({1'b0, r_dvs}),
    .o_diff   (w_diff),
    .o_borrow (w_borrow)
  );

  // The kept difference is always below the divisor, so its top bit is zero.
  assign w_unused_diff_msb = w_diff[WIDTH];

`ifdef SHIFT_SUB_DIVIDER_DIV0_DETECT_EN
  logic r_div0;
  assign w_skip      = r_div0;
  assign div_by_zero = r_div0;
`else
  assign w_skip      = 1'b0;
  assign div_by_zero = 1'b0;
`endif

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = r_out_valid;
  assign quotient    = r_quo;
  assign remainder   = r_rem;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (in_valid) w_next_state = CALC;
      CALC: begin
        if (w_skip)                  w_next_state = DONE;
        else if (r_cnt == LAST_STEP) w_next_state = SIGN;
      end
      SIGN: w_next_state = DONE;
      DONE: if (r_out_valid && out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_qsign     <= 1'b0;
      r_rsign     <= 1'b0;
      r_out_valid <= 1'b0;
`ifdef SHIFT_SUB_DIVIDER_DIV0_DETECT_EN
      r_div0      <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_dvd   <= dividend[WIDTH-1] ? (~dividend + ONE) : dividend;
            r_dvs   <= divisor[WIDTH-1]  ? (~divisor + ONE)  : divisor;
            r_qsign <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_rsign <= dividend[WIDTH-1];
            r_cnt   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
`ifdef SHIFT_SUB_DIVIDER_DIV0_DETECT_EN
            // Final results are loaded now; CALC only spends one edge on the way to DONE.
            r_div0  <= (divisor == '0);
            if (divisor == '0) begin
              r_quo <= '1;
              r_rem <= dividend;
            end
`endif
          end
        end
        CALC: begin
          if (!w_skip) begin
            r_rem <= w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], ~w_borrow};
            r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        SIGN: begin
          if (r_qsign) r_quo <= ~r_quo + ONE;
          if (r_rsign) r_rem <= ~r_rem + ONE;
        end
        DONE: begin
          // out_valid rises one edge after entering DONE and drops on the take edge.
          if (!r_out_valid)    r_out_valid <= 1'b1;
          else if (out_ready)  r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sub_divider.sv
// Bench for shift_sub_divider (WIDTH=32). The driver pushes expected results
// into exp_q when an operation is issued; the monitor pops and compares on
// every result handshake, including the accept-to-valid latency.
module tb_shift_sub_divider;

  localparam int W = 32;

`ifdef SHIFT_SUB_DIVIDER_DIV0_DETECT_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif
  localparam int LAT   = W + 2;
  localparam int LAT0  = DZ_EN ? 2 : W + 2;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic [1:0]   dbg_state;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   accept_edge = 0;
  int   take_edge = 0;
  int   lat_meas = 0;
  bit   seen_valid = 1'b0;
  int   spurious = 0;
  bit   count_spurious = 1'b0;

  shift_sub_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%h required=0x%h", name, act, req);
    end
  endtask

  // Edge counter and acceptance tracking (in_ready read before the DUT updates).
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n && in_valid && in_ready) accept_edge = cyc;
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      seen_valid = 1'b0;
    end else if (out_valid) begin
      if (count_spurious) spurious++;
      if (!seen_valid) begin
        seen_valid = 1'b1;
        lat_meas   = cyc - accept_edge;
      end
      if (out_ready) begin
        take_edge = cyc + 1;
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("quotient", quotient, e.q);
          check("remainder", remainder, e.r);
          check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
          check("latency", lat_meas, e.lat);
        end
        seen_valid = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit push,
                       input logic [W-1:0] q, input logic [W-1:0] r,
                       input logic dz, input int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'd0, 32'd1);
      return;
    end
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    if (push) exp_q.push_back('{q: q, r: r, dz: dz, lat: lat});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] q, input logic [W-1:0] r,
                     input logic dz, input int lat);
    issue(a, b, 1'b1, q, r, dz, lat);
    drain();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    #23;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_div_by_zero", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, LAT);
    run(-32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, LAT);
    run(32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0, LAT);
    run(-32'sd100, -32'sd7, 32'd14, 32'hFFFF_FFFE, 1'b0, LAT);
    run(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, LAT);
    run(32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, LAT);
    run(32'd7, 32'd100, 32'd0, 32'd7, 1'b0, LAT);
    run(32'h7FFF_FFFF, 32'd2, 32'h3FFF_FFFF, 32'd1, 1'b0, LAT);
    run(-32'sd7, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, LAT);
    run(32'd0, 32'd5, 32'd0, 32'd0, 1'b0, LAT);
    run(32'd55, 32'd0, 32'hFFFF_FFFF, 32'd55, DZ_EN, LAT0);
    run(-32'sd55, 32'd0, DZ_EN ? 32'hFFFF_FFFF : 32'd1, 32'hFFFF_FFC9, DZ_EN, LAT0);

    // Result held while the consumer stalls; in_valid activity is ignored.
    out_ready = 1'b0;
    issue(32'd1000, 32'd10, 1'b1, 32'd100, 32'd0, 1'b0, LAT);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("hold_valid_seen", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_quotient", quotient, 32'd100);
      check("hold_remainder", remainder, 32'd0);
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      in_valid = ~in_valid;
      dividend = $urandom_range(0, 32'hFFFF);
      divisor  = $urandom_range(1, 255);
    end
    // Release the result with a new operation already waiting.
    in_valid  = 1'b1;
    dividend  = 32'd9;
    divisor   = 32'd2;
    exp_q.push_back('{q: 32'd4, r: 32'd1, dz: 1'b0, lat: LAT});
    out_ready = 1'b1;
    @(negedge clk);
    check("take_out_valid_low", {31'd0, out_valid}, 32'd0);
    check("take_in_ready_high", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("accept_after_take", accept_edge, take_edge + 1);
    drain();

    // Reset in the middle of CALC discards the operation.
    issue(32'h7FFF_FFFF, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0, 0);
    repeat (9) @(negedge clk);
    check("mid_calc_state", {30'd0, dbg_state}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_quotient", quotient, 32'd0);
    check("mid_rst_remainder", remainder, 32'd0);
    check("mid_rst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_spurious = 1'b1;
    repeat (40) @(negedge clk);
    count_spurious = 1'b0;
    check("no_result_after_reset", spurious, 32'd0);
    run(32'd21, 32'd4, 32'd5, 32'd1, 1'b0, LAT);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
